// File: rtl/atomic_pkg.sv
// Shared definitions for the atomic path: op codes, serializer FSM encoding,
// and an index-width helper for priority encoders.
package atomic_pkg;

    localparam logic [2:0] ATOM_ADD = 3'd0;
    localparam logic [2:0] ATOM_CAS = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } aws_state_t;

    // A single-lane warp still needs a 1-bit lane index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/atomic_lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask; purely combinational.
// idx is 0 when the mask is empty, so callers qualify it with any.
module atomic_lane_pick
    import atomic_pkg::*;
#(
    parameter int LANES = 4,
    parameter int IDX_W = idx_w(LANES)
) (
    input  logic [LANES-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
    end

    assign any = |mask;

endmodule

// File: rtl/atomic_warp_serializer.sv
// Serializes one warp atomic into single-lane atomic_unit requests, lowest lane first.
// Latency >= 2k+1 cycles for k lanes; au_req held until ready, warp_resp held until ready.
module atomic_warp_serializer
    import atomic_pkg::*;
#(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int OP_W   = 3,
    parameter int LANES  = 4,
    parameter int TAG_W  = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    warp_req_valid,
    output logic                    warp_req_ready,
    input  logic [TAG_W-1:0]        warp_req_tag,
    input  logic [LANES-1:0]        warp_req_mask,
    input  logic [OP_W-1:0]         warp_req_op,
    input  logic [LANES*ADDR_W-1:0] warp_req_addr,
    input  logic [LANES*DATA_W-1:0] warp_req_src,
    output logic                    au_req_valid,
    input  logic                    au_req_ready,
    output logic [ADDR_W-1:0]       au_req_addr,
    output logic [OP_W-1:0]         au_req_op,
    output logic [DATA_W-1:0]       au_req_src,
    input  logic                    au_resp_valid,
    input  logic [DATA_W-1:0]       au_resp_data,
    output logic                    warp_resp_valid,
    input  logic                    warp_resp_ready,
    output logic [TAG_W-1:0]        warp_resp_tag,
    output logic [LANES-1:0]        warp_resp_mask,
    output logic [LANES*DATA_W-1:0] warp_resp_data
);

    localparam int IDX_W = idx_w(LANES);

    aws_state_t              state, state_nxt;
    logic [TAG_W-1:0]        tag_q;
    logic [LANES-1:0]        mask_q;
    logic [OP_W-1:0]         op_q;
    logic [LANES*ADDR_W-1:0] addr_q;
    logic [LANES*DATA_W-1:0] src_q;
    logic [LANES*DATA_W-1:0] data_q;
    logic [LANES-1:0]        pending_q;
    logic [IDX_W-1:0]        inflight_q;
    logic [IDX_W-1:0]        cur;
    logic                    cur_any;
    logic                    accept;

    atomic_lane_pick #(.LANES(LANES), .IDX_W(IDX_W)) u_pick (
        .mask (pending_q),
        .idx  (cur),
        .any  (cur_any)
    );

    assign accept = warp_req_valid && warp_req_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = (warp_req_mask == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (au_req_ready) state_nxt = ST_WAIT;
            ST_WAIT:  if (au_resp_valid) state_nxt = (|pending_q) ? ST_ISSUE : ST_DONE;
            ST_DONE:  if (warp_resp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        warp_req_ready  = (state == ST_IDLE);
        au_req_valid    = (state == ST_ISSUE) && cur_any;
        warp_resp_valid = (state == ST_DONE);
    end

    // Responses outside WAIT fall through every arm below and touch nothing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q      <= '0;
            mask_q     <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            data_q     <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    tag_q     <= warp_req_tag;
                    mask_q    <= warp_req_mask;
                    op_q      <= warp_req_op;
                    addr_q    <= warp_req_addr;
                    src_q     <= warp_req_src;
                    pending_q <= warp_req_mask;
                    data_q    <= '0;
                end
                ST_ISSUE: if (au_req_ready) begin
                    pending_q[cur] <= 1'b0;
                    inflight_q     <= cur;
                end
                ST_WAIT: if (au_resp_valid) begin
                    data_q[inflight_q*DATA_W +: DATA_W] <= au_resp_data;
                end
                default: ;
            endcase
        end
    end

    assign au_req_addr    = addr_q[cur*ADDR_W +: ADDR_W];
    assign au_req_src     = src_q[cur*DATA_W +: DATA_W];
    assign au_req_op      = op_q;
    assign warp_resp_tag  = tag_q;
    assign warp_resp_mask = mask_q;
    assign warp_resp_data = data_q;

endmodule

// File: tb/tb_atomic_warp_serializer.sv
// Directed bench for atomic_warp_serializer: table of warp vectors plus
// hand-written backpressure, spurious-response and mid-operation reset sequences.
module tb_atomic_warp_serializer;

    localparam int ADDR_W = 40;
    localparam int DATA_W = 64;
    localparam int OP_W   = 3;
    localparam int LANES  = 4;
    localparam int TAG_W  = 6;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    warp_req_valid;
    logic                    warp_req_ready;
    logic [TAG_W-1:0]        warp_req_tag;
    logic [LANES-1:0]        warp_req_mask;
    logic [OP_W-1:0]         warp_req_op;
    logic [LANES*ADDR_W-1:0] warp_req_addr;
    logic [LANES*DATA_W-1:0] warp_req_src;
    logic                    au_req_valid;
    logic                    au_req_ready;
    logic [ADDR_W-1:0]       au_req_addr;
    logic [OP_W-1:0]         au_req_op;
    logic [DATA_W-1:0]       au_req_src;
    logic                    au_resp_valid;
    logic [DATA_W-1:0]       au_resp_data;
    logic                    warp_resp_valid;
    logic                    warp_resp_ready;
    logic [TAG_W-1:0]        warp_resp_tag;
    logic [LANES-1:0]        warp_resp_mask;
    logic [LANES*DATA_W-1:0] warp_resp_data;

    always #5 clk = ~clk;

    atomic_warp_serializer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OP_W(OP_W), .LANES(LANES), .TAG_W(TAG_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .warp_req_valid  (warp_req_valid),
        .warp_req_ready  (warp_req_ready),
        .warp_req_tag    (warp_req_tag),
        .warp_req_mask   (warp_req_mask),
        .warp_req_op     (warp_req_op),
        .warp_req_addr   (warp_req_addr),
        .warp_req_src    (warp_req_src),
        .au_req_valid    (au_req_valid),
        .au_req_ready    (au_req_ready),
        .au_req_addr     (au_req_addr),
        .au_req_op       (au_req_op),
        .au_req_src      (au_req_src),
        .au_resp_valid   (au_resp_valid),
        .au_resp_data    (au_resp_data),
        .warp_resp_valid (warp_resp_valid),
        .warp_resp_ready (warp_resp_ready),
        .warp_resp_tag   (warp_resp_tag),
        .warp_resp_mask  (warp_resp_mask),
        .warp_resp_data  (warp_resp_data)
    );

    // order: issue sequence, 2 bits per request; rdata: unit reply per request in issue order.
    typedef struct {
        logic [3:0]   mask;
        logic [5:0]   tag;
        logic [2:0]   op;
        logic [159:0] addr;
        logic [255:0] src;
        logic [255:0] rdata;
        logic [255:0] exp_data;
        logic [7:0]   order;
        int           issues;
        int           lat;
    } vec_t;

    vec_t vecs[4];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int req_stall, input int rsp_stall, input bit spurious);
        int       n = 0;
        int       cyc = 1;
        int       lane;
        int       stall0 = req_stall;
        bit       resp_due = 0;
        bit       spur_done = 0;
        bit       seen_resp = 0;
        bit       done = 0;
        logic [63:0] resp_d = '0;

        @(negedge clk);
        warp_req_valid = 1'b1;
        warp_req_tag   = v.tag;
        warp_req_mask  = v.mask;
        warp_req_op    = v.op;
        warp_req_addr  = v.addr;
        warp_req_src   = v.src;
        chk("req_ready_idle", 256'(warp_req_ready), 256'(1));
        @(negedge clk);
        warp_req_valid = 1'b0;
        warp_req_tag   = '1;
        warp_req_mask  = '1;
        warp_req_op    = '1;
        warp_req_addr  = '1;
        warp_req_src   = '1;

        while (!done && cyc < 300) begin
            au_resp_valid   = resp_due;
            au_resp_data    = resp_d;
            resp_due        = 1'b0;
            au_req_ready    = 1'b0;
            warp_resp_ready = 1'b0;
            if (au_req_valid) begin
                if (n >= v.issues) begin
                    chk("extra_au_req", 256'(n), 256'(v.issues));
                    lane = 0;
                end else begin
                    lane = int'(v.order[n*2 +: 2]);
                end
                chk("au_addr", 256'(au_req_addr), 256'(v.addr[lane*40 +: 40]));
                chk("au_src", 256'(au_req_src), 256'(v.src[lane*64 +: 64]));
                chk("au_op", 256'(au_req_op), 256'(v.op));
                if (req_stall > 0) begin
                    req_stall--;
                    if (spurious && !spur_done) begin
                        au_resp_valid = 1'b1;
                        au_resp_data  = 64'hDEAD_BEEF_0BAD_F00D;
                        spur_done     = 1'b1;
                    end
                end else begin
                    au_req_ready = 1'b1;
                    resp_due     = 1'b1;
                    resp_d       = v.rdata[n*64 +: 64];
                    n++;
                end
            end
            if (warp_resp_valid) begin
                if (!seen_resp) begin
                    chk("resp_latency", 256'(cyc), 256'(v.lat + stall0));
                    chk("issue_count", 256'(n), 256'(v.issues));
                    seen_resp = 1'b1;
                end
                chk("resp_tag", 256'(warp_resp_tag), 256'(v.tag));
                chk("resp_mask", 256'(warp_resp_mask), 256'(v.mask));
                chk("resp_data", warp_resp_data, v.exp_data);
                chk("req_ready_busy", 256'(warp_req_ready), 256'(0));
                if (rsp_stall > 0) rsp_stall--;
                else begin
                    warp_resp_ready = 1'b1;
                    done = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        au_req_ready    = 1'b0;
        au_resp_valid   = 1'b0;
        warp_resp_ready = 1'b0;
        if (!done) chk("timeout", 256'(0), 256'(1));
        chk("req_ready_after", 256'(warp_req_ready), 256'(1));
        chk("resp_valid_after", 256'(warp_resp_valid), 256'(0));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 256'(warp_req_ready), 256'(1));
        chk("rst_au_valid", 256'(au_req_valid), 256'(0));
        chk("rst_resp_valid", 256'(warp_resp_valid), 256'(0));
        chk("rst_au_addr", 256'(au_req_addr), 256'(0));
        chk("rst_au_src", 256'(au_req_src), 256'(0));
        chk("rst_au_op", 256'(au_req_op), 256'(0));
        chk("rst_resp_tag", 256'(warp_resp_tag), 256'(0));
        chk("rst_resp_mask", 256'(warp_resp_mask), 256'(0));
        chk("rst_resp_data", warp_resp_data, 256'(0));
    endtask

    initial begin
        vecs[0] = '{mask: 4'b0100, tag: 6'h01, op: 3'd0,
                    addr: {40'hAAA, 40'h100, 40'hBBB, 40'hCCC},
                    src: {64'h99, 64'h5, 64'h77, 64'h66},
                    rdata: {192'h0, 64'h2A},
                    exp_data: {64'h0, 64'h2A, 64'h0, 64'h0},
                    order: 8'b00_00_00_10, issues: 1, lat: 3};
        vecs[1] = '{mask: 4'b1111, tag: 6'h22, op: 3'd1,
                    addr: {40'h18, 40'h10, 40'h8, 40'h0},
                    src: {64'h44, 64'h33, 64'h22, 64'h11},
                    rdata: {64'h1003, 64'h1002, 64'h1001, 64'h1000},
                    exp_data: {64'h1003, 64'h1002, 64'h1001, 64'h1000},
                    order: 8'b11_10_01_00, issues: 4, lat: 9};
        vecs[2] = '{mask: 4'b0000, tag: 6'h15, op: 3'd0,
                    addr: {40'h1, 40'h2, 40'h3, 40'h4},
                    src: {64'h1, 64'h2, 64'h3, 64'h4},
                    rdata: 256'h0, exp_data: 256'h0,
                    order: 8'h00, issues: 0, lat: 1};
        vecs[3] = '{mask: 4'b1010, tag: 6'h3F, op: 3'd0,
                    addr: {40'h40, 40'h500, 40'h40, 40'h600},
                    src: {64'h9, 64'h3, 64'h7, 64'h1},
                    rdata: {128'h0, 64'h66, 64'h55},
                    exp_data: {64'h66, 64'h0, 64'h55, 64'h0},
                    order: 8'b00_00_11_01, issues: 2, lat: 5};

        rstn            = 1'b0;
        warp_req_valid  = 1'b1;
        warp_req_tag    = 6'h2B;
        warp_req_mask   = 4'hF;
        warp_req_op     = 3'd1;
        warp_req_addr   = '1;
        warp_req_src    = '1;
        au_req_ready    = 1'b0;
        au_resp_valid   = 1'b0;
        au_resp_data    = '0;
        warp_resp_ready = 1'b0;
        #22;
        chk_reset_outputs();
        warp_req_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 256'(warp_req_ready), 256'(1));
        chk("post_rst_au_valid", 256'(au_req_valid), 256'(0));

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 0, 0, 1'b0);

        // Both-side backpressure on the full warp, then a spurious reply during ISSUE.
        run_vec(vecs[1], 5, 3, 1'b0);
        run_vec(vecs[0], 2, 0, 1'b1);

        // Reset while lane 0 is in flight; a late reply after release must be ignored.
        @(negedge clk);
        warp_req_valid = 1'b1;
        warp_req_tag   = vecs[1].tag;
        warp_req_mask  = vecs[1].mask;
        warp_req_op    = vecs[1].op;
        warp_req_addr  = vecs[1].addr;
        warp_req_src   = vecs[1].src;
        @(negedge clk);
        warp_req_valid = 1'b0;
        chk("mr_au_valid", 256'(au_req_valid), 256'(1));
        au_req_ready = 1'b1;
        @(negedge clk);
        au_req_ready = 1'b0;
        chk("mr_in_wait", 256'(au_req_valid), 256'(0));
        rstn = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        au_resp_valid = 1'b1;
        au_resp_data  = 64'h1234;
        @(negedge clk);
        au_resp_valid = 1'b0;
        chk("late_resp_idle", 256'(warp_req_ready), 256'(1));
        chk("late_resp_valid", 256'(warp_resp_valid), 256'(0));
        chk("late_resp_data", warp_resp_data, 256'(0));

        run_vec(vecs[3], 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atomic_warp_serializer.md
# atomic_warp_serializer

Upstream feeder of `atomic_unit`. Accepts one warp-wide atomic request (per-lane address/operand, active mask, one op) from the SM. Issues active lanes one at a time, lowest lane first, over the unit's single-lane request port, and collects each completion into a per-lane result slot. When every active lane has completed, it returns one warp response.

## Interface
Parameters:
- `ADDR_W`, 40, byte address width (matches `atomic_unit`)
- `DATA_W`, 64, operand/result width
- `OP_W`, 3, op code width (0=ADD, 1=CAS)
- `LANES`, 4, lanes per warp request (≥1)
- `TAG_W`, 6, warp tag width, passed through unchanged

Ports:
- Clocking: one clock; reset is asynchronous and active-low (`clk`, `rstn`).
- `clk`  in  1  clock
- `rstn`  in  1  async active-low reset
- `warp_req_valid`  in  1  warp request valid
- `warp_req_ready`  out  1  high only in IDLE
- `warp_req_tag`  in  TAG_W  warp tag
- `warp_req_mask`  in  LANES  active-lane mask, bit i = lane i
- `warp_req_op`  in  OP_W  op for all lanes
- `warp_req_addr`  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
- `warp_req_src`  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- `au_req_valid`  out  1  single-lane request to atomic unit
- `au_req_ready`  in  1  atomic unit ready
- `au_req_addr`  out  ADDR_W  selected lane address
- `au_req_op`  out  OP_W  latched op
- `au_req_src`  out  DATA_W  selected lane operand
- `au_resp_valid`  in  1  one-cycle completion pulse, no backpressure
- `au_resp_data`  in  DATA_W  completion data
- `warp_resp_valid`  out  1  warp result valid, held until accepted
- `warp_resp_ready`  in  1  consumer ready
- `warp_resp_tag`  out  TAG_W  latched tag
- `warp_resp_mask`  out  LANES  latched mask
- `warp_resp_data`  out  LANES*DATA_W  per-lane results; inactive lanes read 0

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- IDLE:
  - On `warp_req_valid && warp_req_ready`, latch tag, mask, op, addr and src.
  - Set `pending = mask` and clear all result slots to 0.
  - If mask==0, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - `au_req_valid`=1.
  - `au_req_addr/src` come from lane `cur` = lowest set bit of `pending`.
  - On `au_req_ready`: clear `pending[cur]`, register `cur` as `inflight`, go to WAIT.
- WAIT:
  - On `au_resp_valid`, write `au_resp_data` into slot `inflight`.
  - If `pending` is nonzero, go to ISSUE; otherwise go to DONE.
  - Exactly one lane is in flight at any time.
- DONE: `warp_resp_valid`=1. On `warp_resp_ready`, go to IDLE.
- `au_resp_valid` in any state other than WAIT is ignored: slots are unchanged and the state is unchanged.
- Lanes with duplicate addresses are issued separately, in lane order. No coalescing.
- Op value is forwarded unmodified; no decode in this block.

## Timing
- Reset values:
  - State IDLE.
  - `warp_req_ready`=1 (requests sampled while `rstn`=0 are ignored).
  - `au_req_valid`=0, `warp_resp_valid`=0.
  - `au_req_addr/src`, `au_req_op`, `warp_resp_tag/mask/data` = 0.
- Output decode:
  - `au_req_*`, `warp_req_ready` and `warp_resp_valid` decode combinationally from the registered state.
  - Payloads come straight from registers; no combinational path from any input to any output.
- Accept at edge T0. ISSUE is the cycle after T0, so `au_req_valid` is first high in cycle T0+1.
- Per lane, minimum is 2 cycles (ISSUE + a WAIT of ≥1 cycle).
- `warp_resp_valid` rises in the cycle after the last `au_resp_valid`.
- A k-lane warp against a unit with zero stall needs ≥2k+1 cycles from accept to `warp_resp_valid`.
- Payload stability:
  - `au_req_valid` is held with a stable payload until `au_req_ready`.
  - `warp_resp_*` is stable while valid and not yet ready.
- After DONE handshake, `warp_req_ready` returns high in the next cycle. No same-cycle back-to-back accept.
- Reset asserted mid-operation: the in-flight warp is dropped and outputs go to reset values immediately (async). Any later `au_resp_valid` is ignored because the state is IDLE.

## Structure
- Shared package `atomic_pkg`, shared with `atomic_unit`:
  - op codes `ATOM_ADD`=0, `ATOM_CAS`=1
  - FSM state encoding
- Sub-module `atomic_lane_pick`:
  - Parameterized LANES priority encoder.
  - Inputs: mask. Outputs: lowest-set index (`$clog2(LANES)` bits, min 1) and `any` flag.
  - Used in ISSUE; the WAIT→ISSUE/DONE decision reads `pending` directly.

## Test plan
- Single lane: mask=4'b0100, addr2=0x100, src2=5, op=ADD, unit returns 0x2A → exactly one au request (addr 0x100, src 5); warp_resp data lane2=0x2A, other lanes 0, tag echoed.
- Full warp, in-order issue: mask=4'hF, distinct addrs 0x0/0x8/0x10/0x18 → au requests in lane order 0,1,2,3; each result lands in its own slot; `warp_resp_valid` arrives 1 cycle after the 4th response.
- Empty mask: mask=0, tag=0x15 → no au_req_valid ever; warp_resp_valid at T0+1 with data all 0, mask 0, tag 0x15.
- Backpressure, au side: au_req_ready held low 5 cycles in ISSUE → au_req_valid and payload stable throughout; no lane skipped.
- Backpressure, warp side: warp_resp_ready low 3 cycles → outputs stable; warp_req_ready stays 0 until after the handshake.
- Spurious response and reset:
  - au_resp_valid while in ISSUE → ignored.
  - rstn dropped in WAIT, then released → outputs at reset values during reset; the next warp completes normally.
